// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment readback path: active-low a..g digit
// patterns and the converter FSM state encoding.
package ssd_pkg;

    localparam logic [6:0] SSD_0     = 7'b0000001;
    localparam logic [6:0] SSD_1     = 7'b1001111;
    localparam logic [6:0] SSD_2     = 7'b0010010;
    localparam logic [6:0] SSD_3     = 7'b0000110;
    localparam logic [6:0] SSD_4     = 7'b1001100;
    localparam logic [6:0] SSD_5     = 7'b0100100;
    localparam logic [6:0] SSD_6     = 7'b0100000;
    localparam logic [6:0] SSD_7     = 7'b0001111;
    localparam logic [6:0] SSD_8     = 7'b0000000;
    localparam logic [6:0] SSD_9     = 7'b0001100;
    localparam logic [6:0] SSD_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ssd_digit_decode.sv
// One seven-segment pattern to BCD plus legality flag.
// With BLANK_AS_ZERO_EN defined an all-off digit is accepted as 0.
module ssd_digit_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SSD_0: bcd = 4'd0;
            SSD_1: bcd = 4'd1;
            SSD_2: bcd = 4'd2;
            SSD_3: bcd = 4'd3;
            SSD_4: bcd = 4'd4;
            SSD_5: bcd = 4'd5;
            SSD_6: bcd = 4'd6;
            SSD_7: bcd = 4'd7;
            SSD_8: bcd = 4'd8;
            SSD_9: bcd = 4'd9;
`ifdef BLANK_AS_ZERO_EN
            SSD_BLANK: bcd = 4'd0;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_to_binary.sv
// Converts DIGITS captured seven-segment patterns into one unsigned binary value.
// Blank-digit handling is set by BLANK_AS_ZERO_EN inside ssd_digit_decode.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | IN_READY high, waiting for a frame
// ST_DECODE  | latch per-digit BCD and error flag, clear accumulator
// ST_CONVERT | fold one digit per cycle, most significant digit first
// ST_DONE    | OUT_VALID high, result held until OUT_READY
module ssd_to_binary
    import ssd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [7*DIGITS-1:0]   SEG_IN,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [BIN_W-1:0]      BIN,
    output logic                  ERR
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                  state;
    logic [7*DIGITS-1:0]     seg_q;
    logic [DIGITS-1:0][3:0]  bcd_dec;
    logic [DIGITS-1:0][3:0]  bcd_q;
    logic [DIGITS-1:0]       legal;
    logic                    err_q;
    logic [IW-1:0]           idx;
    logic [BIN_W-1:0]        acc;
    logic [BIN_W-1:0]        acc_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dec
        ssd_digit_decode u_dec (
            .seg   (seg_q[7*i +: 7]),
            .legal (legal[i]),
            .bcd   (bcd_dec[i])
        );
    end

    // acc * 10 + digit without a multiplier
    assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(bcd_q[idx]);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= ST_IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            BIN       <= '0;
            ERR       <= 1'b0;
            seg_q     <= '0;
            bcd_q     <= '0;
            err_q     <= 1'b0;
            idx       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        seg_q    <= SEG_IN;
                        IN_READY <= 1'b0;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    bcd_q <= bcd_dec;
                    err_q <= ~&legal;
                    acc   <= '0;
                    idx   <= IW'(DIGITS - 1);
                    state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    acc <= acc_next;
                    if (idx == '0) begin
                        OUT_VALID <= 1'b1;
                        BIN       <= err_q ? '0 : acc_next;
                        ERR       <= err_q;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_to_binary.sv
// Directed bench for ssd_to_binary: vector table plus stall, reset and back-to-back sequences.
module tb_ssd_to_binary;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] seg_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  bin;
    logic        err;

    int checks = 0;
    int errors = 0;

    ssd_to_binary #(.DIGITS(3), .BIN_W(10)) dut (
        .CLOCK_50  (clk),
        .RESET     (reset),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .SEG_IN    (seg_in),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .BIN       (bin),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] seg;
        logic [9:0]  bin;
        logic        err;
    } vec_t;

    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic logic [20:0] mk(input int d2, input int d1, input int d0);
        return {code(d2), code(d1), code(d0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a frame and return right after the capture edge.
    task automatic start_frame(input logic [20:0] seg, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_in_ready_wait"}, in_ready, 1);
        seg_in   = seg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seg_in   = $urandom;
        chk({nm, "_in_ready_low"}, in_ready, 0);
    endtask

    // Capture, then expect OUT_VALID exactly four edges after the capture edge.
    task automatic frame_to_done(input logic [20:0] seg, input logic [9:0] eb,
                                 input logic ee, input string nm);
        start_frame(seg, nm);
        chk({nm, "_lat0"}, out_valid, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk({nm, "_lat"}, out_valid, 0);
        end
        tick();
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_bin"}, bin, eb);
        chk({nm, "_err"}, err, ee);
        chk({nm, "_busy"}, in_ready, 0);
    endtask

    task automatic accept(input logic [9:0] eb, input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_ov_clear"}, out_valid, 0);
        chk({nm, "_ready_back"}, in_ready, 1);
        chk({nm, "_bin_kept"}, bin, eb);
    endtask

    vec_t vecs[11];

    initial begin
        int last;
        int nres;
        logic prev_ov;

        vecs[0]  = '{mk(9, 9, 9), 10'd999, 1'b0};
        vecs[1]  = '{mk(0, 4, 2), 10'd42,  1'b0};
        vecs[2]  = '{mk(0, 0, 0), 10'd0,   1'b0};
        vecs[3]  = '{mk(4, 2, 99), 10'd0,  1'b1};
        vecs[4]  = '{mk(1, 2, 3), 10'd123, 1'b0};
        vecs[5]  = '{mk(7, 0, 8), 10'd708, 1'b0};
        vecs[6]  = '{mk(5, 6, 1), 10'd561, 1'b0};
        vecs[7]  = '{mk(8, 3, 0), 10'd830, 1'b0};
        vecs[8]  = '{{code(2), 7'b0110000, code(5)}, 10'd0, 1'b1};
`ifdef BLANK_AS_ZERO_EN
        vecs[9]  = '{{BLANK, BLANK, BLANK},   10'd0, 1'b0};
        vecs[10] = '{{BLANK, BLANK, code(7)}, 10'd7, 1'b0};
`else
        vecs[9]  = '{{BLANK, BLANK, BLANK},   10'd0, 1'b1};
        vecs[10] = '{{BLANK, BLANK, code(7)}, 10'd0, 1'b1};
`endif

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        seg_in    = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bin", bin, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 11; i++) begin
            frame_to_done(vecs[i].seg, vecs[i].bin, vecs[i].err, $sformatf("vec%0d", i));
            accept(vecs[i].bin, $sformatf("vec%0d", i));
        end

        // Stall with OUT_READY low while the source wiggles its side.
        frame_to_done(mk(0, 4, 2), 10'd42, 1'b0, "stall");
        for (int k = 0; k < 10; k++) begin
            in_valid = ~in_valid;
            seg_in   = $urandom;
            tick();
            chk("stall_ov", out_valid, 1);
            chk("stall_bin", bin, 42);
            chk("stall_err", err, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        accept(10'd42, "stall");
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stall_no_2nd_capture", out_valid, 0);
        end

        // Reset while converting drops the frame.
        start_frame(mk(9, 8, 7), "rstmid");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_bin", bin, 0);
        chk("rstmid_err", err, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rstmid_dropped", out_valid, 0);
        end
        frame_to_done(mk(1, 2, 3), 10'd123, 1'b0, "after_rst");
        accept(10'd123, "after_rst");

        // Back-to-back frames with the consumer always ready.
        seg_in    = mk(3, 1, 4);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        last      = -1;
        nres      = 0;
        prev_ov   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (prev_ov) chk("b2b_ready_after_accept", in_ready, 1);
            if (out_valid) begin
                chk("b2b_bin", bin, 314);
                chk("b2b_ready_not_same_cycle", in_ready, 0);
                if (last >= 0) chk("b2b_period", c - last, 6);
                last = c;
                nres++;
            end
            prev_ov = out_valid;
        end
        chk("b2b_count", nres, 6);
        in_valid = 1'b0;
        repeat (10) tick();
        chk("b2b_drained", out_valid, 0);
        chk("b2b_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
